i2c_target_regs: RTL

//  I2C target (responder) with an 8-bit register file, the bus-side counterpart of our I2C

---
 rtl/i2c_pkg.sv | 31 +++
 rtl/i2c_line_sync.sv | 84 ++++++++
 rtl/i2c_target_regs.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register block.
package i2c_pkg;

  // Target protocol states
  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_P
  } tgt_state_e;

  // SDA level in the ninth (acknowledge) bit slot
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Direction bit carried in the LSB of the address byte
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // 3-input majority vote used by the optional line glitch filter
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA line conditioning: synchronizers, optional majority glitch filter
// (enabled by defining I2C_TGT_GLITCH_FILTER_EN), and registered single-cycle
// pulses for SCL rise/fall, START and STOP.
module i2c_line_sync
  import i2c_pkg::*;
#(
  parameter int SYNC_STG = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic SclIn,
  input  logic SdaIn,
  output logic SdaLevel,
  output logic SclRise,
  output logic SclFall,
  output logic StartDet,
  output logic StopDet
);

  logic [SYNC_STG-1:0] sclSync;
  logic [SYNC_STG-1:0] sdaSync;
  logic                sclLine;
  logic                sdaLine;
  logic                sclPrev;
  logic                sdaPrev;

  // Synchronizer chains; reset to the idle-bus level so reset release creates no edges
  // NOTE: state is updated with <= so every flop samples the pre-edge value of its source.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sclSync <= '1;
      sdaSync <= '1;
    end else begin
      sclSync <= {sclSync[SYNC_STG-2:0], SclIn};
      sdaSync <= {sdaSync[SYNC_STG-2:0], SdaIn};
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [1:0] sclHist;
  logic [1:0] sdaHist;

  // Majority over three consecutive samples drops any single-cycle pulse
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sclHist <= '1;
      sdaHist <= '1;
      sclLine <= 1'b1;
      sdaLine <= 1'b1;
    end else begin
      sclHist <= {sclHist[0], sclSync[SYNC_STG-1]};
      sdaHist <= {sdaHist[0], sdaSync[SYNC_STG-1]};
      sclLine <= maj3(sclSync[SYNC_STG-1], sclHist[0], sclHist[1]);
      sdaLine <= maj3(sdaSync[SYNC_STG-1], sdaHist[0], sdaHist[1]);
    end
  end
`else
  assign sclLine = sclSync[SYNC_STG-1];
  assign sdaLine = sdaSync[SYNC_STG-1];
`endif

  // Edge and bus-condition pulses; START/STOP need SCL high on both samples so an
  // SDA change that coincides with an SCL change is never mistaken for one
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sclPrev  <= 1'b1;
      sdaPrev  <= 1'b1;
      SdaLevel <= 1'b1;
      SclRise  <= 1'b0;
      SclFall  <= 1'b0;
      StartDet <= 1'b0;
      StopDet  <= 1'b0;
    end else begin
      sclPrev  <= sclLine;
      sdaPrev  <= sdaLine;
      SdaLevel <= sdaLine;
      SclRise  <= sclLine & ~sclPrev;
      SclFall  <= ~sclLine & sclPrev;
      StartDet <= sclLine & sclPrev & sdaPrev & ~sdaLine;
      StopDet  <= sclLine & sclPrev & ~sdaPrev & sdaLine;
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with an 8-bit register file: pointer write, data write and data
// read with auto-increment. SDA is driven open-drain through SdaOe. Defining
// I2C_TGT_GLITCH_FILTER_EN adds a majority glitch filter on both bus lines.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] TGT_ADDR = 7'h48,
  parameter int         NUM_REGS = 8,
  parameter int         SYNC_STG = 2
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        SclIn,
  input  logic                        SdaIn,
  output logic                        SdaOe,
  input  logic                        HostWrEn,
  input  logic [$clog2(NUM_REGS)-1:0] HostWrAddr,
  input  logic [7:0]                  HostWrData,
  output logic [8*NUM_REGS-1:0]       RegOut,
  output logic                        WrStrobe,
  output logic [$clog2(NUM_REGS)-1:0] WrAddr,
  output logic                        Busy
);

  localparam int PW = $clog2(NUM_REGS);

  logic sdaLevel;
  logic sclRise;
  logic sclFall;
  logic startDet;
  logic stopDet;

  tgt_state_e    state;
  tgt_state_e    stateNext;
  logic [3:0]    bitCnt;
  logic [3:0]    bitCntNext;
  logic [7:0]    shReg;
  logic [7:0]    shRegNext;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptrNext;
  logic          rwFlag;
  logic          rwNext;
  logic          sdaOeNext;
  logic          busyNext;
  logic          wrStrobeNext;
  logic [PW-1:0] wrAddrNext;
  logic          busWrEn;
  logic [7:0]    rxByte;
  logic          rxShift;
  logic          byteDone;
  logic [7:0]    regFile [NUM_REGS];

  i2c_line_sync #(
    .SYNC_STG (SYNC_STG)
  ) u_line_sync (
    .Clk      (Clk),
    .Reset    (Reset),
    .SclIn    (SclIn),
    .SdaIn    (SdaIn),
    .SdaLevel (sdaLevel),
    .SclRise  (sclRise),
    .SclFall  (sclFall),
    .StartDet (startDet),
    .StopDet  (stopDet)
  );

  // bitCnt counts received bits; 8 means the byte is complete and awaits its ACK slot
  assign rxByte   = {shReg[6:0], sdaLevel};
  assign byteDone = (bitCnt == 4'd8);
  assign rxShift  = sclRise && !byteDone;

  // Next-state and datapath decode; STOP and START override every state
  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    stateNext    = state;
    bitCntNext   = bitCnt;
    shRegNext    = shReg;
    ptrNext      = ptr;
    rwNext       = rwFlag;
    sdaOeNext    = SdaOe;
    busyNext     = Busy;
    wrStrobeNext = 1'b0;
    wrAddrNext   = WrAddr;
    busWrEn      = 1'b0;

    if (stopDet) begin
      stateNext  = IDLE;
      bitCntNext = 4'd0;
      sdaOeNext  = 1'b0;
      busyNext   = 1'b0;
    end else if (startDet) begin
      stateNext  = ADDR;
      bitCntNext = 4'd0;
      sdaOeNext  = 1'b0;
    end else begin
      case (state)
        IDLE: ;

        ADDR: begin
          if (rxShift) begin
            shRegNext  = rxByte;
            bitCntNext = bitCnt + 4'd1;
          end else if (sclFall && byteDone) begin
            if (shReg[7:1] == TGT_ADDR) begin
              stateNext = ADDR_ACK;
              sdaOeNext = 1'b1;
              busyNext  = 1'b1;
              rwNext    = shReg[0];
              if (shReg[0] == RW_READ) shRegNext = regFile[ptr];
            end else begin
              stateNext = WAIT_P;
              busyNext  = 1'b0;
            end
          end
        end

        ADDR_ACK: begin
          if (sclFall) begin
            bitCntNext = 4'd0;
            if (rwFlag == RW_READ) begin
              stateNext = RDATA;
              sdaOeNext = ~shReg[7];
            end else begin
              stateNext = PTR;
              sdaOeNext = 1'b0;
            end
          end
        end

        PTR: begin
          if (rxShift) begin
            shRegNext  = rxByte;
            bitCntNext = bitCnt + 4'd1;
          end else if (sclFall && byteDone) begin
            ptrNext   = shReg[PW-1:0];
            stateNext = PTR_ACK;
            sdaOeNext = 1'b1;
          end
        end

        PTR_ACK, WDATA_ACK: begin
          if (sclFall) begin
            stateNext  = WDATA;
            bitCntNext = 4'd0;
            sdaOeNext  = 1'b0;
          end
        end

        WDATA: begin
          if (rxShift) begin
            shRegNext  = rxByte;
            bitCntNext = bitCnt + 4'd1;
            if (bitCnt == 4'd7) begin
              busWrEn      = 1'b1;
              wrStrobeNext = 1'b1;
              wrAddrNext   = ptr;
              ptrNext      = ptr + 1'b1;
            end
          end else if (sclFall && byteDone) begin
            stateNext = WDATA_ACK;
            sdaOeNext = 1'b1;
          end
        end

        RDATA: begin
          if (sclFall) begin
            if (bitCnt == 4'd7) begin
              stateNext  = RDATA_ACK;
              bitCntNext = 4'd0;
              sdaOeNext  = 1'b0;
              ptrNext    = ptr + 1'b1;
            end else begin
              shRegNext  = {shReg[6:0], 1'b0};
              sdaOeNext  = ~shReg[6];
              bitCntNext = bitCnt + 4'd1;
            end
          end
        end

        // bitCnt=1 here records that the master ACKed and the next byte is loaded
        RDATA_ACK: begin
          if (sclRise) begin
            if (sdaLevel == I2C_ACK) begin
              shRegNext  = regFile[ptr];
              bitCntNext = 4'd1;
            end else begin
              stateNext = WAIT_P;
            end
          end else if (sclFall && bitCnt == 4'd1) begin
            stateNext  = RDATA;
            bitCntNext = 4'd0;
            sdaOeNext  = ~shReg[7];
          end
        end

        WAIT_P: sdaOeNext = 1'b0;

        default: begin
          stateNext = IDLE;
          sdaOeNext = 1'b0;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Datapath and output registers; SdaOe clears asynchronously with Reset
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bitCnt   <= 4'd0;
      shReg    <= 8'h00;
      ptr      <= '0;
      rwFlag   <= RW_WRITE;
      SdaOe    <= 1'b0;
      Busy     <= 1'b0;
      WrStrobe <= 1'b0;
      WrAddr   <= '0;
    end else begin
      bitCnt   <= bitCntNext;
      shReg    <= shRegNext;
      ptr      <= ptrNext;
      rwFlag   <= rwNext;
      SdaOe    <= sdaOeNext;
      Busy     <= busyNext;
      WrStrobe <= wrStrobeNext;
      WrAddr   <= wrAddrNext;
    end
  end

  // Register file; the bus write comes last so it wins a same-cycle collision
  // NOTE: this small flop array is reset on purpose because software expects all-zero
  // contents after reset; a RAM-backed array would not take a reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) regFile[i] <= 8'h00;
    end else begin
      if (HostWrEn) regFile[HostWrAddr] <= HostWrData;
      if (busWrEn)  regFile[ptr]        <= rxByte;
    end
  end

  // Flatten the register file onto RegOut
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regout
    assign RegOut[8*gi +: 8] = regFile[gi];
  end

endmodule
